// File: rtl/sipo_frame_if.sv
// Bundles the serial input side and the registered word output of sipo_frame.
// The slave modport is the receiver; the master modport is whoever drives the
// serial lines and consumes words. r_parity_err_out exists only when
// SIPO_FRAME_PARITY_EN is defined.
interface sipo_frame_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 1
);
    logic [LANES-1:0] data_in;
    logic             en_in;
    logic             frame_in;
    logic             clear_in;
    logic             ready_in;
    logic [WIDTH-1:0] r_data_out;
    logic             r_valid_out;
    logic             r_overrun_out;
`ifdef SIPO_FRAME_PARITY_EN
    logic             r_parity_err_out;

    modport master (
        output data_in, en_in, frame_in, clear_in, ready_in,
        input  r_data_out, r_valid_out, r_overrun_out, r_parity_err_out
    );
    modport slave (
        input  data_in, en_in, frame_in, clear_in, ready_in,
        output r_data_out, r_valid_out, r_overrun_out, r_parity_err_out
    );
`else
    modport master (
        output data_in, en_in, frame_in, clear_in, ready_in,
        input  r_data_out, r_valid_out, r_overrun_out
    );
    modport slave (
        input  data_in, en_in, frame_in, clear_in, ready_in,
        output r_data_out, r_valid_out, r_overrun_out
    );
`endif
endinterface

// File: rtl/sipo_frame.sv
// Framed multi-lane serial-to-parallel receiver. Shifts LANES bits per beat
// (en_in && frame_in) and, after WIDTH/LANES beats, presents the word on a
// registered valid/ready slot with a sticky overrun flag.
// Optional macro SIPO_FRAME_PARITY_EN: each word takes one extra beat that
// carries an even-parity bit on data_in[0], reported as r_parity_err_out.
module sipo_frame #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    sipo_frame_if.slave sif
);
    localparam int BEATS = WIDTH / LANES;
    localparam int CNT_W = $clog2(BEATS + 1);
`ifdef SIPO_FRAME_PARITY_EN
    localparam int LAST_BEAT = BEATS;
`else
    localparam int LAST_BEAT = BEATS - 1;
`endif

    if ((WIDTH % LANES) != 0) begin : g_param_check
        $error("sipo_frame: WIDTH must be a multiple of LANES");
    end

    logic [WIDTH-1:0] sreg_q, sreg_d, shifted;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             slot_free;
`ifdef SIPO_FRAME_PARITY_EN
    logic             perr_q, perr_d;
`endif

    // Shift-register next value: new lanes enter at the top (LSB-first) or bottom (MSB-first)
    if (LANES >= WIDTH) begin : g_shift_full
        logic unused_sreg;
        assign unused_sreg = ^sreg_q;
        assign shifted     = sif.data_in;
    end else if (MSB_FIRST != 0) begin : g_shift_msb
        logic unused_top;
        assign unused_top = ^sreg_q[WIDTH-1:WIDTH-LANES];
        assign shifted    = {sreg_q[WIDTH-LANES-1:0], sif.data_in};
    end else begin : g_shift_lsb
        logic unused_bot;
        assign unused_bot = ^sreg_q[LANES-1:0];
        assign shifted    = {sif.data_in, sreg_q[WIDTH-1:LANES]};
    end

    // Beat counting, word completion and output-slot handshake
    always_comb begin
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
`ifdef SIPO_FRAME_PARITY_EN
        perr_d    = perr_q;
`endif
        slot_free = !valid_q || sif.ready_in;

        if (valid_q && sif.ready_in) begin
            valid_d = 1'b0;
        end
        if (sif.clear_in) begin
            ovr_d = 1'b0;
        end

        if (!sif.frame_in) begin
            cnt_d = '0;
        end else if (sif.en_in) begin
            if (cnt_q == CNT_W'(LAST_BEAT)) begin
                cnt_d = '0;
                if (slot_free) begin
                    valid_d = 1'b1;
`ifdef SIPO_FRAME_PARITY_EN
                    // The word is already complete; this beat only carries parity.
                    data_d  = sreg_q;
                    perr_d  = (^sreg_q) ^ sif.data_in[0];
`else
                    data_d  = shifted;
`endif
                end else begin
                    // Set wins over a simultaneous clear.
                    ovr_d = 1'b1;
                end
`ifndef SIPO_FRAME_PARITY_EN
                sreg_d = shifted;
`endif
            end else begin
                cnt_d  = cnt_q + 1'b1;
                sreg_d = shifted;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sreg_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
`ifdef SIPO_FRAME_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign sif.r_data_out    = data_q;
    assign sif.r_valid_out   = valid_q;
    assign sif.r_overrun_out = ovr_q;
`ifdef SIPO_FRAME_PARITY_EN
    assign sif.r_parity_err_out = perr_q;
`endif
endmodule

// File: tb/tb_sipo_frame.sv
// Bench for sipo_frame: a main 8-bit LSB-first single-lane instance checked every
// cycle against a beat-queue model, plus MSB-first and two-lane instances for
// bit-order checks. Honours SIPO_FRAME_PARITY_EN.
module tb_sipo_frame;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sipo_frame_if #(.WIDTH(8), .LANES(1)) bus ();
    sipo_frame_if #(.WIDTH(8), .LANES(1)) msb_bus ();
    sipo_frame_if #(.WIDTH(8), .LANES(2)) l2_bus ();

    sipo_frame #(.WIDTH(8), .LANES(1), .MSB_FIRST(0)) u_main (.clk_in(clk), .rst_n_in(rst_n), .sif(bus));
    sipo_frame #(.WIDTH(8), .LANES(1), .MSB_FIRST(1)) u_msb  (.clk_in(clk), .rst_n_in(rst_n), .sif(msb_bus));
    sipo_frame #(.WIDTH(8), .LANES(2), .MSB_FIRST(0)) u_l2   (.clk_in(clk), .rst_n_in(rst_n), .sif(l2_bus));

`ifdef SIPO_FRAME_PARITY_EN
    localparam int NBEATS = 9;
    localparam int MSB_NB = 9;
    localparam int L2_NB  = 5;
`else
    localparam int NBEATS = 8;
    localparam int MSB_NB = 8;
    localparam int L2_NB  = 4;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model of the main instance
    bit         beats[$];
    logic [7:0] exp_data;
    logic       exp_valid, exp_ovr, exp_perr;

    function automatic bit par(input logic [7:0] w);
        return ^w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Next expected state from the inputs presented this cycle.
    task automatic model_step();
        logic [7:0] word;
        logic       nvalid, novr, free;
        if (!rst_n) begin
            beats.delete();
            exp_data = '0; exp_valid = 1'b0; exp_ovr = 1'b0; exp_perr = 1'b0;
            return;
        end
        free   = !exp_valid || bus.ready_in;
        nvalid = exp_valid && !bus.ready_in;
        novr   = bus.clear_in ? 1'b0 : exp_ovr;
        if (!bus.frame_in) begin
            beats.delete();
        end else if (bus.en_in) begin
            beats.push_back(bus.data_in[0]);
            if (beats.size() == NBEATS) begin
                word = '0;
                for (int k = 0; k < 8; k++) word = word | (8'(beats[k]) << k);
                if (free) begin
                    exp_data = word;
                    nvalid   = 1'b1;
`ifdef SIPO_FRAME_PARITY_EN
                    exp_perr = (^word) ^ beats[8];
`endif
                end else begin
                    novr = 1'b1;
                end
                beats.delete();
            end
        end
        exp_valid = nvalid;
        exp_ovr   = novr;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("valid", 32'(bus.r_valid_out), 32'(exp_valid));
        chk("data", 32'(bus.r_data_out), 32'(exp_data));
        chk("overrun", 32'(bus.r_overrun_out), 32'(exp_ovr));
`ifdef SIPO_FRAME_PARITY_EN
        chk("parity_err", 32'(bus.r_parity_err_out), 32'(exp_perr));
`endif
    endtask

    // One full word LSB-first (plus parity beat when enabled); ready_in on the last beat separately.
    task automatic send_word(input logic [7:0] w, input bit pbit, input bit rdy, input bit rdy_last);
        bus.frame_in = 1'b1;
        bus.en_in    = 1'b1;
        for (int k = 0; k < NBEATS; k++) begin
            bus.data_in  = (k < 8) ? w[k[2:0]] : pbit;
            bus.ready_in = (k == NBEATS - 1) ? rdy_last : rdy;
            step();
        end
        bus.en_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] s;
        logic [7:0] l2s;
        rst_n = 1'b0;
        bus.data_in = '0; bus.en_in = 1'b0; bus.frame_in = 1'b0; bus.clear_in = 1'b0; bus.ready_in = 1'b0;
        msb_bus.data_in = '0; msb_bus.en_in = 1'b0; msb_bus.frame_in = 1'b1; msb_bus.clear_in = 1'b0; msb_bus.ready_in = 1'b1;
        l2_bus.data_in = '0; l2_bus.en_in = 1'b0; l2_bus.frame_in = 1'b1; l2_bus.clear_in = 1'b0; l2_bus.ready_in = 1'b1;
        step();
        step();
        chk("reset_data", 32'(bus.r_data_out), 32'h0);
        chk("reset_valid", 32'(bus.r_valid_out), 32'h0);
        chk("reset_ovr", 32'(bus.r_overrun_out), 32'h0);

        // Basic LSB-first word, single-cycle valid with ready held high
        rst_n = 1'b1;
        bus.frame_in = 1'b1;
        bus.ready_in = 1'b1;
        send_word(8'h4D, par(8'h4D), 1'b1, 1'b1);
        chk("lsb_data", 32'(bus.r_data_out), 32'h4D);
        chk("lsb_valid", 32'(bus.r_valid_out), 32'h1);
        step();
        chk("lsb_valid_drop", 32'(bus.r_valid_out), 32'h0);

        // Bit order: MSB-first instance and two-lane instance
        s   = 8'h4D;
        l2s = 8'h8D;
        for (int k = 0; k < MSB_NB; k++) begin
            msb_bus.en_in   = 1'b1;
            msb_bus.data_in = (k < 8) ? s[k[2:0]] : 1'b0;
            l2_bus.en_in    = (k < L2_NB);
            l2_bus.data_in  = (k < 4) ? l2s[(2 * (k % 4)) +: 2] : 2'b00;
            step();
            if (k == L2_NB - 1) begin
                chk("l2_data", 32'(l2_bus.r_data_out), 32'h8D);
                chk("l2_valid", 32'(l2_bus.r_valid_out), 32'h1);
            end
            if (k == MSB_NB - 1) begin
                chk("msb_data", 32'(msb_bus.r_data_out), 32'hB2);
                chk("msb_valid", 32'(msb_bus.r_valid_out), 32'h1);
            end
        end
        msb_bus.en_in = 1'b0;
        l2_bus.en_in  = 1'b0;

        // Overrun, clear, then drain
        send_word(8'h4D, par(8'h4D), 1'b0, 1'b0);
        send_word(8'hB2, par(8'hB2), 1'b0, 1'b0);
        chk("ovr_data_kept", 32'(bus.r_data_out), 32'h4D);
        chk("ovr_flag", 32'(bus.r_overrun_out), 32'h1);
        bus.clear_in = 1'b1;
        step();
        bus.clear_in = 1'b0;
        chk("ovr_cleared", 32'(bus.r_overrun_out), 32'h0);
        chk("ovr_valid_held", 32'(bus.r_valid_out), 32'h1);
        bus.ready_in = 1'b1;
        step();
        chk("drain_valid", 32'(bus.r_valid_out), 32'h0);

        // Accept and completion in the same cycle
        send_word(8'h3C, par(8'h3C), 1'b0, 1'b0);
        send_word(8'hC3, par(8'hC3), 1'b0, 1'b1);
        chk("b2b_data", 32'(bus.r_data_out), 32'hC3);
        chk("b2b_valid", 32'(bus.r_valid_out), 32'h1);
        chk("b2b_no_ovr", 32'(bus.r_overrun_out), 32'h0);

        // Overrun set wins over a simultaneous clear
        bus.clear_in = 1'b1;
        send_word(8'h22, par(8'h22), 1'b0, 1'b0);
        bus.clear_in = 1'b0;
        chk("set_wins", 32'(bus.r_overrun_out), 32'h1);
        bus.clear_in = 1'b1;
        bus.ready_in = 1'b1;
        step();
        bus.clear_in = 1'b0;

        // Abort a partial word with frame low for one cycle
        bus.en_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.data_in = 1'($urandom);
            step();
        end
        bus.frame_in = 1'b0;
        step();
        send_word(8'hA5, par(8'hA5), 1'b1, 1'b1);
        chk("abort_data", 32'(bus.r_data_out), 32'hA5);

        // Reset in the middle of a word
        bus.frame_in = 1'b1;
        bus.en_in    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.data_in = 1'($urandom);
            step();
        end
        rst_n = 1'b0;
        step();
        chk("midrst_data", 32'(bus.r_data_out), 32'h0);
        chk("midrst_valid", 32'(bus.r_valid_out), 32'h0);
        rst_n = 1'b1;
        send_word(8'h5A, par(8'h5A), 1'b1, 1'b1);
        chk("post_rst_data", 32'(bus.r_data_out), 32'h5A);

`ifdef SIPO_FRAME_PARITY_EN
        // Parity beat: correct, wrong, and valid only after the ninth beat
        send_word(8'h4D, 1'b0, 1'b1, 1'b1);
        chk("par_ok", 32'(bus.r_parity_err_out), 32'h0);
        send_word(8'h4D, 1'b1, 1'b1, 1'b1);
        chk("par_bad", 32'(bus.r_parity_err_out), 32'h1);
        step();
        bus.en_in = 1'b1;
        for (int k = 0; k < 9; k++) begin
            bus.data_in = (k < 8) ? s[k[2:0]] : 1'b0;
            step();
            if (k == 7) chk("par_no_valid_8", 32'(bus.r_valid_out), 32'h0);
            if (k == 8) chk("par_valid_9", 32'(bus.r_valid_out), 32'h1);
        end
        bus.en_in = 1'b0;
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst_n        = ($urandom_range(0, 63) != 0);
            bus.frame_in = ($urandom_range(0, 15) != 0);
            bus.en_in    = ($urandom_range(0, 3) != 0);
            bus.ready_in = 1'($urandom);
            bus.clear_in = ($urandom_range(0, 7) == 0);
            bus.data_in  = 1'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sipo_frame.md
Name: sipo_frame

Overview:
- Framed, multi-lane serial-to-parallel receiver. Generalised successor of the single-lane shift-in register.
- Shifts LANES bits per sample strobe and counts beats to a full WIDTH-bit word. Bit order is selectable.
- Each word is presented on a registered valid/ready output with overrun detection.
- Sits between pin-level serial links (stepper driver readback, SPI-like status streams) and word-oriented control logic.

Parameters:
- WIDTH, 8, word size in bits; must be a multiple of LANES (elaboration error otherwise)
- LANES, 1, serial data lines sampled per beat
- MSB_FIRST, 0, 0 = first beat lands in the lowest bits; 1 = first beat lands in the highest bits

Ports:
- clk_in  input  1  clock; all logic on the rising edge
- rst_n_in  input  1  synchronous, active-low reset
- data_in  input  LANES  serial data, sampled when en_in && frame_in
- en_in  input  1  sample strobe; one beat per cycle it is high
- frame_in  input  1  frame active; low discards any partial word
- clear_in  input  1  clears the sticky overrun flag
- ready_in  input  1  consumer accepts r_data_out when r_valid_out is high
- r_data_out  output  WIDTH  last completed word, registered
- r_valid_out  output  1  r_data_out holds an unaccepted word
- r_overrun_out  output  1  sticky flag: a completed word was dropped

Behaviour:
- Reset (rst_n_in low at a clock edge) forces all of the following to 0: r_data_out, r_valid_out, r_overrun_out, the shift register and the beat counter. Reset mid-word discards the partial word.
- BEATS = WIDTH/LANES. The beat counter is ceil(log2(BEATS+1)) bits wide and runs 0..BEATS-1.
- Beat = en_in && frame_in. en_in is ignored while frame_in is low.
- Shift when MSB_FIRST=0: sreg_next = {data_in, sreg[WIDTH-1:LANES]}.
- Shift when MSB_FIRST=1: sreg_next = {sreg[WIDTH-LANES-1:0], data_in}.
- Non-final beat: the counter increments.
- Final beat (counter == BEATS-1): the counter wraps to 0 and the word completes using sreg_next, i.e. including the current beat.
- Completion latency: r_data_out and r_valid_out update on the same edge that samples the final beat.
- Output slot is free if r_valid_out == 0 or ready_in == 1 in that cycle.
  - Free: r_data_out <= sreg_next; r_valid_out <= 1.
  - Not free: the word is dropped, r_data_out is unchanged and r_overrun_out <= 1.
- Handshake:
  - r_data_out stays stable while r_valid_out is high.
  - Transfer occurs when r_valid_out && ready_in at an edge; r_valid_out then clears unless a new word completes in the same cycle.
  - Accept and completion in the same cycle: the new word loads and r_valid_out stays 1, with no bubble and no overrun.
- frame_in low: the counter resets to 0 the next edge. The shift register contents become don't-care. The output slot is unaffected.
- frame_in rising: the next beat is beat 0 with no extra delay. A frame may carry any number of back-to-back words.
- clear_in: r_overrun_out <= 0. If an overrun occurs in the same cycle, set wins.
- ready_in is ignored while r_valid_out is 0.

Optional Feature:
- Macro SIPO_FRAME_PARITY_EN.
- Defined:
  - Each word takes BEATS+1 beats. The extra final beat carries an even-parity bit on data_in[0]; the other lanes are ignored.
  - Port r_parity_err_out (output, 1 bit) is added. It is loaded together with r_data_out: 1 when the XOR of the word and the parity bit is 1.
  - It is held with the word, follows the same handshake, drops with the word on overrun, and resets to 0.
- Undefined: the port is absent and the word completes after BEATS beats.

Test Plan:
- WIDTH=8, LANES=1, MSB_FIRST=0, ready_in=1; beats 1,0,1,1,0,0,1,0 -> r_data_out=0x4D and r_valid_out=1 on the 8th sampling edge, then 0 the following cycle.
- Same stream with MSB_FIRST=1 -> 0xB2. With WIDTH=8, LANES=2, MSB_FIRST=0, beats 2'b01, 2'b11, 2'b00, 2'b10 -> 0x8D after 4 beats.
- ready_in=0; send 0x4D then 0xB2 -> r_data_out remains 0x4D and r_overrun_out=1. Then clear_in=1 for one cycle -> r_overrun_out=0. Then ready_in=1 -> r_valid_out drops.
- Back-to-back words with ready_in pulsed exactly on the completion cycle of word 2 -> word 2 loads, r_valid_out stays 1, no overrun.
- Abort and reset:
  - 3 beats, frame_in low for 1 cycle, then 0xA5 LSB-first -> r_data_out=0xA5.
  - rst_n_in low after 5 beats -> all outputs 0; the next 8 beats form a clean word.
- SIPO_FRAME_PARITY_EN defined:
  - 0x4D followed by parity beat 0 -> r_parity_err_out=0.
  - 0x4D followed by parity beat 1 -> r_parity_err_out=1.
  - Valid asserts only after the 9th beat.
